contador_updown_param: RTL and testbench



---
 rtl/contador_pkg.sv | 14 +
 rtl/contador_passo.sv | 80 ++++++++
 rtl/contador_updown_param.sv | 149 ++++++++++++++
 tb/tb_contador_updown_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and constants for the parametrised up/down/ping-pong counter.
package contador_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'b00,
        MODE_DOWN     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/contador_passo.sv
// Combinational step: from the current count, direction and mode, produces the next
// count, the next direction and whether the step lands on a terminal endpoint.
module contador_passo
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LO    = 0,
    parameter int HI    = 15
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             direction_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] next_count_o,
    output logic             next_dir_o,
    output logic             hit_o
);

    localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic eff_dir_s;

    // Next-state arithmetic for each counting mode; wrap only happens at LO/HI.
    always_comb begin
        next_count_o = count_i;
        next_dir_o   = direction_i;
        hit_o        = 1'b0;
        eff_dir_s    = direction_i;
        case (mode_i)
            MODE_UP: begin
                if (count_i == HI_V) begin
                    next_count_o = LO_V;
                end else begin
                    next_count_o = count_i + ONE;
                end
                next_dir_o = DIR_UP;
                hit_o      = (next_count_o == HI_V);
            end
            MODE_DOWN: begin
                if (count_i == LO_V) begin
                    next_count_o = HI_V;
                end else begin
                    next_count_o = count_i - ONE;
                end
                next_dir_o = DIR_DOWN;
                hit_o      = (next_count_o == LO_V);
            end
            MODE_PINGPONG: begin
                // Endpoints force the turn-around regardless of the stored flag.
                if (count_i == HI_V) begin
                    eff_dir_s = DIR_DOWN;
                end else if (count_i == LO_V) begin
                    eff_dir_s = DIR_UP;
                end else begin
                    eff_dir_s = direction_i;
                end
                if (eff_dir_s == DIR_DOWN) begin
                    next_count_o = count_i - ONE;
                end else begin
                    next_count_o = count_i + ONE;
                end
                if (next_count_o == HI_V) begin
                    next_dir_o = DIR_DOWN;
                end else if (next_count_o == LO_V) begin
                    next_dir_o = DIR_UP;
                end else begin
                    next_dir_o = eff_dir_s;
                end
                hit_o = (next_count_o == HI_V) || (next_count_o == LO_V);
            end
            default: begin
                next_count_o = count_i;
                next_dir_o   = direction_i;
                hit_o        = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/contador_updown_param.sv
// Bounded LO..HI counter with up-wrap/down-wrap/ping-pong/hold modes, clamped load and
// terminal pulse. Define CONTADOR_CYCLE_COUNT_EN to add the completed-cycle counter output.
module contador_updown_param
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LO    = 0,
    parameter int HI    = 15,
    parameter int CYC_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] saida_contador,
    output logic             direction,
    output logic             terminal
`ifdef CONTADOR_CYCLE_COUNT_EN
    ,
    output logic [CYC_W-1:0] ciclos_completos
`endif
);

    localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

    if (LO >= HI) begin : g_bad_bounds
        $error("contador_updown_param: LO must be strictly below HI");
    end
    if (HI > (2 ** WIDTH) - 1) begin : g_bad_hi
        $error("contador_updown_param: HI does not fit in WIDTH bits");
    end
    if (CYC_W < 1) begin : g_bad_cyc
        $error("contador_updown_param: CYC_W must be at least 1");
    end

    function automatic logic [WIDTH-1:0] clamp_value(
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        logic [WIDTH-1:0] r;
        if (v < lo) begin
            r = lo;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             term_q, term_d;
    logic [WIDTH-1:0] next_count_s;
    logic             next_dir_s;
    logic             hit_s;
    logic [WIDTH-1:0] load_v_s;
    mode_e            mode_s;

    assign mode_s   = mode_e'(mode);
    assign load_v_s = clamp_value(load_value, LO_V, HI_V);

    contador_passo #(
        .WIDTH (WIDTH),
        .LO    (LO),
        .HI    (HI)
    ) u_passo (
        .count_i      (count_q),
        .direction_i  (dir_q),
        .mode_i       (mode_s),
        .next_count_o (next_count_s),
        .next_dir_o   (next_dir_s),
        .hit_o        (hit_s)
    );

`ifdef CONTADOR_CYCLE_COUNT_EN
    logic [CYC_W-1:0] ciclos_q, ciclos_d;
`endif

    // Priority: load over enabled step over hold (reset is applied in the register).
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        term_d  = 1'b0;
`ifdef CONTADOR_CYCLE_COUNT_EN
        ciclos_d = ciclos_q;
`endif
        if (load) begin
            count_d = load_v_s;
            if (load_v_s == HI_V) begin
                dir_d = DIR_DOWN;
            end else if (load_v_s == LO_V) begin
                dir_d = DIR_UP;
            end else begin
                dir_d = dir_q;
            end
`ifdef CONTADOR_CYCLE_COUNT_EN
            ciclos_d = {CYC_W{1'b0}};
`endif
        end else if (enable && (mode_s != MODE_HOLD)) begin
            count_d = next_count_s;
            dir_d   = next_dir_s;
            term_d  = hit_s;
`ifdef CONTADOR_CYCLE_COUNT_EN
            // Reaching LO in ping-pong can only come from a downward step: one full cycle.
            if ((mode_s == MODE_PINGPONG) && (next_count_s == LO_V)) begin
                ciclos_d = ciclos_q + CYC_W'(1);
            end else begin
                ciclos_d = ciclos_q;
            end
`endif
        end else begin
            count_d = count_q;
            dir_d   = dir_q;
            term_d  = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= LO_V;
            dir_q   <= DIR_UP;
            term_q  <= 1'b0;
`ifdef CONTADOR_CYCLE_COUNT_EN
            ciclos_q <= {CYC_W{1'b0}};
`endif
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            term_q  <= term_d;
`ifdef CONTADOR_CYCLE_COUNT_EN
            ciclos_q <= ciclos_d;
`endif
        end
    end

    assign saida_contador = count_q;
    assign direction      = dir_q;
    assign terminal       = term_q;
`ifdef CONTADOR_CYCLE_COUNT_EN
    assign ciclos_completos = ciclos_q;
`endif

endmodule

// File: tb/tb_contador_updown_param.sv
// Directed scoreboard bench for contador_updown_param over several bound configurations.
module tb_contador_updown_param;

`ifdef CONTADOR_CYCLE_COUNT_EN
    localparam int NDUT = 3;
`else
    localparam int NDUT = 2;
`endif

    logic       clock;
    logic       rst_a  [NDUT];
    logic       ld_a   [NDUT];
    logic       en_a   [NDUT];
    logic [1:0] md_a   [NDUT];
    logic [4:0] lv_a   [NDUT];
    logic [4:0] cnt_a  [NDUT];
    logic       dir_a  [NDUT];
    logic       term_a [NDUT];
`ifdef CONTADOR_CYCLE_COUNT_EN
    logic [7:0] cyc_0, cyc_1, cyc_2;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         sel;
        logic [4:0] cnt;
        logic       dir;
        logic       term;
        logic [7:0] cyc;
        string      tag;
    } exp_t;
    exp_t sb[$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    contador_updown_param #(.WIDTH(5), .LO(0), .HI(15)) dut0 (
        .clock(clock), .reset(rst_a[0]), .enable(en_a[0]), .mode(md_a[0]),
        .load(ld_a[0]), .load_value(lv_a[0]), .saida_contador(cnt_a[0]),
        .direction(dir_a[0]), .terminal(term_a[0])
`ifdef CONTADOR_CYCLE_COUNT_EN
        , .ciclos_completos(cyc_0)
`endif
    );

    contador_updown_param #(.WIDTH(5), .LO(3), .HI(9)) dut1 (
        .clock(clock), .reset(rst_a[1]), .enable(en_a[1]), .mode(md_a[1]),
        .load(ld_a[1]), .load_value(lv_a[1]), .saida_contador(cnt_a[1]),
        .direction(dir_a[1]), .terminal(term_a[1])
`ifdef CONTADOR_CYCLE_COUNT_EN
        , .ciclos_completos(cyc_1)
`endif
    );

`ifdef CONTADOR_CYCLE_COUNT_EN
    contador_updown_param #(.WIDTH(5), .LO(0), .HI(3)) dut2 (
        .clock(clock), .reset(rst_a[2]), .enable(en_a[2]), .mode(md_a[2]),
        .load(ld_a[2]), .load_value(lv_a[2]), .saida_contador(cnt_a[2]),
        .direction(dir_a[2]), .terminal(term_a[2]), .ciclos_completos(cyc_2)
    );
`endif

    task automatic check_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (cnt_a[e.sel] === e.cnt) else begin
            errors++;
            $error("FAIL %s count: got %0d expected %0d", e.tag, cnt_a[e.sel], e.cnt);
        end
        checks++;
        assert (dir_a[e.sel] === e.dir) else begin
            errors++;
            $error("FAIL %s direction: got %0b expected %0b", e.tag, dir_a[e.sel], e.dir);
        end
        checks++;
        assert (term_a[e.sel] === e.term) else begin
            errors++;
            $error("FAIL %s terminal: got %0b expected %0b", e.tag, term_a[e.sel], e.term);
        end
`ifdef CONTADOR_CYCLE_COUNT_EN
        if (e.sel == 2) begin
            checks++;
            assert (cyc_2 === e.cyc) else begin
                errors++;
                $error("FAIL %s ciclos: got %0d expected %0d", e.tag, cyc_2, e.cyc);
            end
        end
`endif
    endtask

    task automatic step(input int sel, input logic rst, input logic ld, input logic en,
                        input logic [1:0] md, input logic [4:0] lv,
                        input logic [4:0] ec, input logic ed, input logic et,
                        input logic [7:0] ecyc, input string tag);
        exp_t e;
        for (int i = 0; i < NDUT; i++) begin
            rst_a[i] = 1'b0;
            ld_a[i]  = 1'b0;
            en_a[i]  = 1'b0;
        end
        rst_a[sel] = rst;
        ld_a[sel]  = ld;
        en_a[sel]  = en;
        md_a[sel]  = md;
        lv_a[sel]  = lv;
        e.sel = sel; e.cnt = ec; e.dir = ed; e.term = et; e.cyc = ecyc; e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        check_front();
    endtask

    initial begin
        logic [4:0] v;
        logic       d;
        for (int i = 0; i < NDUT; i++) begin
            rst_a[i] = 1'b1; ld_a[i] = 1'b0; en_a[i] = 1'b0;
            md_a[i] = 2'b11; lv_a[i] = 5'd0;
        end

        // Ping-pong over 0..15
        step(0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0, "reset0");
        for (int i = 1; i < 32; i++) begin
            v = (i <= 15) ? 5'(i) : ((i <= 30) ? 5'(30 - i) : 5'(i - 30));
            d = (i >= 15) && (i <= 29);
            step(0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, v, d, (v == 5'd15) || (v == 5'd0),
                 8'd0, "pingpong");
        end

        // Bounded 3..9 up-wrap then down-wrap, then clamped loads
        step(1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 5'd3, 1'b0, 1'b0, 8'd0, "reset1");
        for (int i = 1; i <= 8; i++) begin
            v = 5'(3 + (i % 7));
            step(1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, v, 1'b0, v == 5'd9, 8'd0, "upwrap");
        end
        step(1, 1'b0, 1'b0, 1'b1, 2'b01, 5'd0, 5'd3, 1'b1, 1'b1, 8'd0, "down_lo");
        step(1, 1'b0, 1'b0, 1'b1, 2'b01, 5'd0, 5'd9, 1'b1, 1'b0, 8'd0, "down_wrap");
        step(1, 1'b0, 1'b0, 1'b1, 2'b01, 5'd0, 5'd8, 1'b1, 1'b0, 8'd0, "down_8");
        step(1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd12, 5'd9, 1'b1, 1'b0, 8'd0, "clamp_hi");
        step(1, 1'b0, 1'b1, 1'b1, 2'b00, 5'd1, 5'd3, 1'b0, 1'b0, 8'd0, "clamp_lo");

        // Loads during ping-pong
        step(0, 1'b0, 1'b1, 1'b1, 2'b10, 5'd12, 5'd12, 1'b0, 1'b0, 8'd0, "load12");
        step(0, 1'b0, 1'b1, 1'b1, 2'b10, 5'd20, 5'd15, 1'b1, 1'b0, 8'd0, "load20");
        step(0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 5'd14, 1'b1, 1'b0, 8'd0, "after_load");
        step(0, 1'b0, 1'b1, 1'b1, 2'b10, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0, "load0");

        // Enable gating and hold mode
        step(0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd7, 5'd7, 1'b0, 1'b0, 8'd0, "load7");
        step(0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 5'd8, 1'b0, 1'b0, 8'd0, "en1");
        step(0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd8, 1'b0, 1'b0, 8'd0, "en0a");
        step(0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd8, 1'b0, 1'b0, 8'd0, "en0b");
        step(0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 5'd9, 1'b0, 1'b0, 8'd0, "en1b");
        step(0, 1'b0, 1'b0, 1'b1, 2'b11, 5'd0, 5'd9, 1'b0, 1'b0, 8'd0, "hold_a");
        step(0, 1'b0, 1'b0, 1'b1, 2'b11, 5'd0, 5'd9, 1'b0, 1'b0, 8'd0, "hold_b");

        // Up-wrap at HI, mode switch at HI, reset beats load
        step(0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd15, 5'd15, 1'b1, 1'b0, 8'd0, "load15");
        step(0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0, "wrap_hi");
        step(0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd14, 5'd14, 1'b0, 1'b0, 8'd0, "load14");
        step(0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd0, 5'd15, 1'b0, 1'b1, 8'd0, "up_to_hi");
        step(0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, 5'd14, 1'b1, 1'b0, 8'd0, "switch_pp");
        step(0, 1'b1, 1'b1, 1'b1, 2'b10, 5'd9, 5'd0, 1'b0, 1'b0, 8'd0, "rst_load");

`ifdef CONTADOR_CYCLE_COUNT_EN
        // Completed-cycle counter over 0..3
        step(2, 1'b1, 1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0, "reset2");
        for (int i = 1; i <= 12; i++) begin
            case (i % 6)
                0: v = 5'd0;
                1: v = 5'd1;
                2: v = 5'd2;
                3: v = 5'd3;
                4: v = 5'd2;
                default: v = 5'd1;
            endcase
            d = ((i % 6) >= 3);
            step(2, 1'b0, 1'b0, 1'b1, 2'b10, 5'd0, v, d, (v == 5'd3) || (v == 5'd0),
                 8'(i / 6), "cycles");
        end
        step(2, 1'b0, 1'b1, 1'b1, 2'b10, 5'd2, 5'd2, 1'b0, 1'b0, 8'd0, "cyc_load");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
